fpu_add_arbiter: RTL
====================

Name: fpu_add_arbiter

Overview:
- Shares one fpu_sp_add instance among NUM_REQ requesters (integer unit, FP issue port, debug/test port, and so on).
- Round-robin arbitration with per-requester valid/ready request and response handshakes.
- One operation in flight at a time.
- Drives the adder's operand and dval inputs and captures its registered result on the exact cycle it is valid; the adder zeroes its output whenever dval is low, so the capture cycle is fixed.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADD_LATENCY, 1, cycles from the adder clock edge that samples dval=1 to the first cycle its output holds the result.
- ID_W, 2, width of grant index; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  NUM_REQ*32  operand A, requester i at bits [32*i+31:32*i]
- req_b  in  NUM_REQ*32  operand B, same packing
- req_ready  out  NUM_REQ  one-hot accept; at most one bit high
- resp_valid  out  NUM_REQ  one-hot result valid toward the owning requester
- resp_ready  in  NUM_REQ  per-requester result accept
- resp_data  out  32  IEEE-754 single-precision sum
- busy  out  1  high in any state other than IDLE
- grant_id  out  ID_W  index of the current owner
- add_a  out  32  to adder A
- add_b  out  32  to adder B
- add_dval  out  1  to adder dval
- add_out  in  32  from adder Out

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, owner=0, op_a=op_b=res_q=0, wait_cnt=0.
- Reset values of outputs: req_ready=0, resp_valid=0, resp_data=0, busy=0, grant_id=0, add_a=0, add_b=0, add_dval=0.
- Reset mid-operation drops the in-flight result; no response is ever issued for it.
- State machine with four states:
  - IDLE: the grant is the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around. req_ready[grant]=1 combinationally in the same cycle. On that edge: op_a/op_b <= operands of the granted requester, owner <= grant, rr_ptr <= grant+1 (wrapping at NUM_REQ), go to ISSUE. If no request is valid, stay in IDLE.
  - ISSUE: add_dval=1 for exactly this one cycle; add_a/add_b = op_a/op_b. Next state is WAIT with wait_cnt=1.
  - WAIT: add_dval=0. If wait_cnt==ADD_LATENCY, then res_q <= add_out and go to RESP; otherwise wait_cnt++. There is no second sample; later cycles read zero from the adder.
  - RESP: resp_valid[owner]=1 and resp_data=res_q, both held stable until resp_ready[owner]=1, then go to IDLE. resp_ready bits of non-owners are ignored.
- add_a/add_b hold op_a/op_b in every state; only add_dval marks the operation.
- Latency from request accept edge to first resp_valid cycle: ADD_LATENCY+2. For ADD_LATENCY=1 this is 3 cycles.
- Minimum spacing between accepts: ADD_LATENCY+3 cycles.
- req_ready is 0 outside IDLE. A new grant is never made in the same cycle as a response handshake; the next arbitration happens in the following IDLE cycle.
- Requester-side rules:
  - A requester keeps req_valid and operands stable until req_ready.
  - Dropping req_valid before grant is legal and simply removes it from arbitration.
- grant_id = owner in ISSUE/WAIT/RESP, and the combinational grant in IDLE (0 when nothing is valid).
- No arithmetic is performed here; results are passed through bit-exact from add_out.

Decomposition:
- Shared package fpu_ctrl_pkg:
  - state enum typedef (IDLE, ISSUE, WAIT, RESP), 2 bits.
  - localparam FP_W=32.
  - function rr_pick(req_vec, ptr) returning the grant index and a found flag.
- One sub-module is natural: rr_arbiter_core. It is combinational: priority-rotate over NUM_REQ bits from the pointer, producing the one-hot grant and the index. It is reusable for the other FPU ops.
- The adder is instantiated at the level above; this block only exposes the add_* pins.

Test Plan:
- Single op: requester 0, A=0x3F800000 (1.0), B=0x40000000 (2.0), resp_ready=1.
  - Required: req_ready[0] at T0; add_dval high only at T1; resp_valid[0] at T3 with resp_data=0x40400000.
- Cancellation: requester 2, A=0x3FC00000, B=0xBFC00000 (1.5 and -1.5) -> resp_valid[2]=1, resp_data=0x00000000, grant_id=2.
- Round robin: all four req_valid held high with distinct operands -> grant order 0,1,2,3,0, one accept every 4 cycles, and each resp_valid reaches only its own requester.
- Backpressure: resp_ready[1] held low for 5 cycles during RESP.
  - Required: resp_valid[1] and resp_data stay stable; req_ready stays 0 even with req_valid[3]=1.
  - Required: one cycle after resp_ready[1] rises, requester 3 is granted.
- Reset mid-op: assert rst during WAIT.
  - Required: all outputs are 0 immediately (asynchronously), and no resp_valid ever appears for the dropped op.
  - Required: after release, requester 0 is granted first (rr_ptr=0).
- Latency parameter: ADD_LATENCY=3 with a delayed adder model -> res_q is captured in the 3rd WAIT cycle and resp_valid first appears 5 cycles after accept.

Source files
------------

// File: rtl/fpu_ctrl_pkg.sv
// fpu_ctrl_pkg: shared FSM states, widths and round-robin pick helper for FPU op arbiters
package fpu_ctrl_pkg;
  localparam int FP_W = 32;
  localparam int MAX_REQ = 8;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef struct packed {
    logic found;
    logic [IDX_W-1:0] idx;
  } pick_t;
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req_vec, input logic [IDX_W-1:0] ptr, input int n);
    pick_t p;
    int j;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % n;
      if (k < n && req_vec[IDX_W'(j)]) p = '{found: 1'b1, idx: IDX_W'(j)};
    end
    return p;
  endfunction
endpackage

// File: rtl/fpu_add_arbiter_if.sv
// fpu_add_arbiter_if: requester handshakes plus adder pins of the shared adder arbiter
interface fpu_add_arbiter_if #(parameter int NUM_REQ = 4, parameter int ID_W = 2);
  import fpu_ctrl_pkg::*;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*FP_W-1:0] req_a;
  logic [NUM_REQ*FP_W-1:0] req_b;
  logic [NUM_REQ-1:0] resp_valid;
  logic [NUM_REQ-1:0] resp_ready;
  logic [FP_W-1:0] resp_data;
  logic busy;
  logic [ID_W-1:0] grant_id;
  logic [FP_W-1:0] add_a;
  logic [FP_W-1:0] add_b;
  logic add_dval;
  logic [FP_W-1:0] add_out;
  modport master (
    output req_valid, req_a, req_b, resp_ready, add_out,
    input req_ready, resp_valid, resp_data, busy, grant_id, add_a, add_b, add_dval
  );
  modport slave (
    input req_valid, req_a, req_b, resp_ready, add_out,
    output req_ready, resp_valid, resp_data, busy, grant_id, add_a, add_b, add_dval
  );
endinterface

// File: rtl/rr_arbiter_core.sv
// rr_arbiter_core: combinational round-robin pick starting at ptr, one-hot and index outputs
module rr_arbiter_core
  import fpu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               found
);
  pick_t pick;
  // rotate-priority search over the padded request vector
  always_comb pick = rr_pick(MAX_REQ'(req), IDX_W'(ptr), NUM_REQ);
  assign found = pick.found;
  assign gnt_idx = ID_W'(pick.idx);
  assign gnt_oh = pick.found ? NUM_REQ'(1) << pick.idx : '0;
endmodule

// File: rtl/fpu_add_arbiter.sv
// fpu_add_arbiter: round-robin sharing of one single-precision adder, one op in flight
module fpu_add_arbiter
  import fpu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADD_LATENCY = 1,
  parameter int ID_W = 2
) (
  input logic clk,
  input logic rst,
  fpu_add_arbiter_if.slave bus
);
  localparam int CW = $clog2(ADD_LATENCY + 1);
  state_t state;
  logic [ID_W-1:0] rr_ptr, owner, gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic found, idle_live;
  logic [FP_W-1:0] op_a, op_b, res_q;
  logic [CW-1:0] wait_cnt;
  rr_arbiter_core #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(bus.req_valid),
    .ptr(rr_ptr),
    .gnt_oh(gnt_oh),
    .gnt_idx(gnt_idx),
    .found(found)
  );
  // reset also masks the combinational grant so every output reads zero while rst is high
  assign idle_live = state == IDLE && !rst;
  assign bus.req_ready = idle_live ? gnt_oh : '0;
  assign bus.resp_valid = state == RESP ? NUM_REQ'(1) << owner : '0;
  assign bus.resp_data = res_q;
  assign bus.busy = state != IDLE;
  assign bus.grant_id = state != IDLE ? owner : idle_live ? gnt_idx : '0;
  assign bus.add_a = op_a;
  assign bus.add_b = op_b;
  assign bus.add_dval = state == ISSUE;
  // accept, issue, sample the adder on its single valid cycle, then hold the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      op_a <= '0;
      op_b <= '0;
      res_q <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          op_a <= bus.req_a[int'(gnt_idx)*FP_W +: FP_W];
          op_b <= bus.req_b[int'(gnt_idx)*FP_W +: FP_W];
          owner <= gnt_idx;
          rr_ptr <= gnt_idx == ID_W'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          wait_cnt <= CW'(1);
          state <= WAIT;
        end
        WAIT: if (wait_cnt == CW'(ADD_LATENCY)) begin
          res_q <= bus.add_out;
          state <= RESP;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        RESP: if (bus.resp_ready[owner]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
